// File: rtl/fp32_maxmin_reduce_if.sv
// Handshake bundle for the streaming FP32 max/min reduction unit.
// The master side feeds beats and accepts results; the slave side is the reducer.
interface fp32_maxmin_reduce_if #(
    parameter int LANES = 4,
    parameter int IDX_W = 16
);
    logic                  i_valid;
    logic                  i_ready;
    logic                  i_is_max;
    logic                  i_last;
    logic [LANES-1:0]      i_lane_en;
    logic [LANES*32-1:0]   i_data;
    logic                  o_res_valid;
    logic                  i_res_ready;
    logic [31:0]           o_res;
    logic [IDX_W-1:0]      o_res_idx;
    logic                  o_res_nan;
    logic                  o_res_empty;

    modport master (
        output i_valid, i_is_max, i_last, i_lane_en, i_data, i_res_ready,
        input  i_ready, o_res_valid, o_res, o_res_idx, o_res_nan, o_res_empty
    );

    modport slave (
        input  i_valid, i_is_max, i_last, i_lane_en, i_data, i_res_ready,
        output i_ready, o_res_valid, o_res, o_res_idx, o_res_nan, o_res_empty
    );
endinterface

// File: rtl/fp32_maxmin_reduce.sv
// Streaming FP32 max/min reduction: each frame of LANES-wide beats is reduced to
// one value plus the element index where it first occurred. NaNs dominate, ties
// go to the lower index, and a frame with no enabled element reports empty.
// Pipeline: stage 1 registers the beat, stage 2 folds the lane tree into the
// accumulator, and the result register loads one cycle after the last beat folds.
module fp32_maxmin_reduce #(
    parameter int LANES = 4,
    parameter int IDX_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    fp32_maxmin_reduce_if.slave  bus
);

    localparam int LOG2L = $clog2(LANES);

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        DONE
    } state_t;

    // One candidate element: NaN candidates always beat ordinary ones.
    typedef struct packed {
        logic             valid;
        logic             nan;
        logic [31:0]      val;
        logic [IDX_W-1:0] idx;
    } elem_t;

    state_t state;
    state_t next_state;
    logic   ready;
    logic   accept;

    logic [IDX_W-1:0]    beat_cnt;
    logic                mode_max;
    logic                s1_valid;
    logic                s1_first;
    logic                s1_last;
    logic [LANES-1:0]    s1_en;
    logic [LANES*32-1:0] s1_data;
    logic [IDX_W-1:0]    s1_beat;

    elem_t acc;
    elem_t acc_next;
    logic  s2_last;

    logic             res_valid;
    logic [31:0]      res_val;
    logic [IDX_W-1:0] res_idx;
    logic             res_nan;
    logic             res_empty;

    function automatic logic is_nan(input logic [31:0] v);
        return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
    endfunction

    // Strict ordering: opposite signs favour the positive one (+0 > -0);
    // equal signs compare magnitude, reversed for negatives.
    function automatic logic greater(input logic [31:0] a, input logic [31:0] b);
        if (a[31] != b[31])
            return !a[31];
        else if (!a[31])
            return a[30:0] > b[30:0];
        else
            return a[30:0] < b[30:0];
    endfunction

    // Combine two candidates where lo always carries the lower element index,
    // so the lower index survives ties and the first NaN survives later NaNs.
    function automatic elem_t merge(input elem_t lo, input elem_t hi, input logic is_max);
        if (!hi.valid)
            return lo;
        if (!lo.valid)
            return hi;
        if (lo.nan)
            return lo;
        if (hi.nan)
            return hi;
        if (is_max ? greater(hi.val, lo.val) : greater(lo.val, hi.val))
            return hi;
        return lo;
    endfunction

    // Frame state register.
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Frame sequencing: input closes after the last beat until the result is taken.
    always_comb begin
        next_state = state;
        ready      = 1'b0;
        case (state)
            IDLE: begin
                ready = !rst;
                if (bus.i_valid && !rst)
                    next_state = bus.i_last ? DONE : ACC;
            end
            ACC: begin
                ready = !rst;
                if (bus.i_valid && !rst && bus.i_last)
                    next_state = DONE;
            end
            DONE: begin
                if (res_valid && bus.i_res_ready)
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign accept      = bus.i_valid & ready;
    assign bus.i_ready = ready;

    // Stage 1: capture the accepted beat, its beat number and, on frame start, the mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt <= '0;
            mode_max <= 1'b0;
            s1_valid <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_en    <= '0;
            s1_data  <= '0;
            s1_beat  <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_first <= (state == IDLE);
                s1_last  <= bus.i_last;
                s1_en    <= bus.i_lane_en;
                s1_data  <= bus.i_data;
                if (state == IDLE) begin
                    s1_beat  <= '0;
                    beat_cnt <= IDX_W'(1);
                    mode_max <= bus.i_is_max;
                end else begin
                    s1_beat  <= beat_cnt;
                    beat_cnt <= beat_cnt + 1'b1;
                end
            end
        end
    end

    // Stage 2 combinational path: lane tree, then fold into the running accumulator.
    always_comb begin
        elem_t node [LANES];
        for (int k = 0; k < LANES; k++) begin
            node[k].valid = s1_en[k];
            node[k].nan   = s1_en[k] & is_nan(s1_data[32*k +: 32]);
            node[k].val   = s1_data[32*k +: 32];
            node[k].idx   = (s1_beat << LOG2L) | IDX_W'(k);
        end
        for (int lvl = 0; lvl < LOG2L; lvl++) begin
            for (int k = 0; k < LANES; k += (2 << lvl)) begin
                if (k + (1 << lvl) < LANES)
                    node[k] = merge(node[k], node[k + (1 << lvl)], mode_max);
            end
        end
        acc_next = merge(s1_first ? elem_t'('0) : acc, node[0], mode_max);
    end

    // Stage 2 register: the accumulator only moves when a beat is present.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= '0;
            s2_last <= 1'b0;
        end else begin
            s2_last <= s1_valid & s1_last;
            if (s1_valid)
                acc <= acc_next;
        end
    end

    // Result register: load the finished frame, hold it until the downstream takes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid <= 1'b0;
            res_val   <= '0;
            res_idx   <= '0;
            res_nan   <= 1'b0;
            res_empty <= 1'b0;
        end else if (s2_last) begin
            res_valid <= 1'b1;
            if (!acc.valid) begin
                res_val   <= '0;
                res_idx   <= '0;
                res_nan   <= 1'b0;
                res_empty <= 1'b1;
            end else if (acc.nan) begin
                res_val   <= 32'hFFFF_FFFF;
                res_idx   <= acc.idx;
                res_nan   <= 1'b1;
                res_empty <= 1'b0;
            end else begin
                res_val   <= acc.val;
                res_idx   <= acc.idx;
                res_nan   <= 1'b0;
                res_empty <= 1'b0;
            end
        end else if (res_valid && bus.i_res_ready) begin
            res_valid <= 1'b0;
        end
    end

    assign bus.o_res_valid = res_valid;
    assign bus.o_res       = res_val;
    assign bus.o_res_idx   = res_idx;
    assign bus.o_res_nan   = res_nan;
    assign bus.o_res_empty = res_empty;

endmodule

// File: tb/tb_fp32_maxmin_reduce.sv
// Bench for fp32_maxmin_reduce: directed frames for the documented corner cases,
// then randomized frames with bubbles, compared against a queue-based model
// that orders floats through a monotonic integer key.
module tb_fp32_maxmin_reduce;

    localparam int LANES = 4;
    localparam int IDX_W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fp32_maxmin_reduce_if #(.LANES(LANES), .IDX_W(IDX_W)) bus ();

    fp32_maxmin_reduce #(.LANES(LANES), .IDX_W(IDX_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference model state for the frame in flight.
    int          beatNo;
    logic        frameMax;
    logic [31:0] mVal [$];
    int          mIdx [$];
    logic [31:0] expRes;
    logic [15:0] expIdx;
    logic        expNan;
    logic        expEmpty;

    function automatic logic [127:0] pack4(input logic [31:0] a0, input logic [31:0] a1,
                                           input logic [31:0] a2, input logic [31:0] a3);
        return {a3, a2, a1, a0};
    endfunction

    function automatic logic isNanF(input logic [31:0] v);
        return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
    endfunction

    // Maps FP32 bit patterns onto unsigned integers in the same order (+0 above -0).
    function automatic logic [31:0] orderKey(input logic [31:0] v);
        return v[31] ? ~v : (v | 32'h8000_0000);
    endfunction

    function automatic logic [31:0] randVal();
        logic [31:0] pool [3];
        pool[0] = 32'h3F80_0000;
        pool[1] = 32'hBF80_0000;
        pool[2] = 32'h4040_0000;
        case ($urandom_range(0, 11))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'h7F80_0000;
            3:       return 32'hFF80_0000;
            4:       return 32'h7F80_0000 | 32'($urandom_range(1, 32'h7F_FFFF));
            5, 6, 7: return pool[$urandom_range(0, 2)];
            default: return $urandom();
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic startFrame();
        beatNo = 0;
        mVal.delete();
        mIdx.delete();
    endtask

    task automatic modelResult();
        int best;
        expNan   = 1'b0;
        expEmpty = (mVal.size() == 0);
        expRes   = 32'h0;
        expIdx   = 16'h0;
        foreach (mVal[i]) begin
            if (isNanF(mVal[i]) && !expNan) begin
                expNan = 1'b1;
                expIdx = 16'(mIdx[i]);
            end
        end
        if (expNan) begin
            expRes = 32'hFFFF_FFFF;
        end else if (!expEmpty) begin
            best = 0;
            for (int i = 1; i < mVal.size(); i++) begin
                if (frameMax ? (orderKey(mVal[i]) > orderKey(mVal[best]))
                             : (orderKey(mVal[i]) < orderKey(mVal[best])))
                    best = i;
            end
            expRes = mVal[best];
            expIdx = 16'(mIdx[best]);
        end
    endtask

    // Present one beat, wait (bounded) for acceptance, and record it in the model.
    task automatic applyStimulus(input logic [127:0] data, input logic [3:0] en,
                                 input logic last, input logic isMax);
        int waited = 0;
        if (beatNo == 0)
            frameMax = isMax;
        bus.i_data    = data;
        bus.i_lane_en = en;
        bus.i_last    = last;
        bus.i_is_max  = isMax;
        bus.i_valid   = 1'b1;
        @(negedge clk);
        while (!bus.i_ready && waited < 20) begin
            waited++;
            @(negedge clk);
        end
        if (!bus.i_ready)
            checkOutput("accept_timeout", {31'b0, bus.i_ready}, 32'd1);
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            if (en[k]) begin
                mVal.push_back(data[32*k +: 32]);
                mIdx.push_back((beatNo * LANES + k) & 16'hFFFF);
            end
        end
        beatNo++;
    endtask

    // Called right after the last beat is accepted: checks latency, result and handshake.
    task automatic finishFrame(input string tag, input logic useConst, input logic [31:0] cRes,
                               input logic [15:0] cIdx, input logic cNan, input logic cEmpty);
        modelResult();
        @(negedge clk);
        checkOutput({tag, "_ready_closed"}, {31'b0, bus.i_ready}, 32'd0);
        checkOutput({tag, "_valid_n0"}, {31'b0, bus.o_res_valid}, 32'd0);
        @(negedge clk);
        checkOutput({tag, "_valid_n1"}, {31'b0, bus.o_res_valid}, 32'd0);
        @(negedge clk);
        checkOutput({tag, "_valid_n2"}, {31'b0, bus.o_res_valid}, 32'd1);
        checkOutput({tag, "_res"}, bus.o_res, expRes);
        checkOutput({tag, "_idx"}, {16'b0, bus.o_res_idx}, {16'b0, expIdx});
        checkOutput({tag, "_nan"}, {31'b0, bus.o_res_nan}, {31'b0, expNan});
        checkOutput({tag, "_empty"}, {31'b0, bus.o_res_empty}, {31'b0, expEmpty});
        if (useConst) begin
            checkOutput({tag, "_res_const"}, bus.o_res, cRes);
            checkOutput({tag, "_idx_const"}, {16'b0, bus.o_res_idx}, {16'b0, cIdx});
            checkOutput({tag, "_nan_const"}, {31'b0, bus.o_res_nan}, {31'b0, cNan});
            checkOutput({tag, "_empty_const"}, {31'b0, bus.o_res_empty}, {31'b0, cEmpty});
        end
        if (bus.i_res_ready) begin
            @(negedge clk);
            checkOutput({tag, "_valid_drop"}, {31'b0, bus.o_res_valid}, 32'd0);
            checkOutput({tag, "_ready_reopen"}, {31'b0, bus.i_ready}, 32'd1);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic        anyValid;
        logic [31:0] heldRes;
        int          nb;
        int          bubble;

        bus.i_valid     = 1'b0;
        bus.i_is_max    = 1'b0;
        bus.i_last      = 1'b0;
        bus.i_lane_en   = '0;
        bus.i_data      = '0;
        bus.i_res_ready = 1'b1;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_ready", {31'b0, bus.i_ready}, 32'd0);
        checkOutput("rst_valid", {31'b0, bus.o_res_valid}, 32'd0);
        checkOutput("rst_res", bus.o_res, 32'd0);
        checkOutput("rst_idx", {16'b0, bus.o_res_idx}, 32'd0);
        checkOutput("rst_nan", {31'b0, bus.o_res_nan}, 32'd0);
        checkOutput("rst_empty", {31'b0, bus.o_res_empty}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("post_rst_ready", {31'b0, bus.i_ready}, 32'd1);
        @(posedge clk);
        #1;

        $display("[TB] directed: two-beat max with tie");
        startFrame();
        applyStimulus(pack4(32'h3F80_0000, 32'h4040_0000, 32'hC000_0000, 32'h3F00_0000), 4'b1111, 1'b0, 1'b1);
        applyStimulus(pack4(32'h4040_0000, 32'h4020_0000, 32'h8000_0000, 32'h0000_0000), 4'b1111, 1'b1, 1'b1);
        finishFrame("tp_max2", 1'b1, 32'h4040_0000, 16'd1, 1'b0, 1'b0);

        $display("[TB] directed: signed zeros, min then max");
        startFrame();
        applyStimulus(pack4(32'h8000_0000, 32'h0000_0000, 32'h3F80_0000, 32'h4000_0000), 4'b1111, 1'b1, 1'b0);
        finishFrame("tp_min_zero", 1'b1, 32'h8000_0000, 16'd0, 1'b0, 1'b0);
        startFrame();
        applyStimulus(pack4(32'h8000_0000, 32'h0000_0000, 32'h3F80_0000, 32'h4000_0000), 4'b1111, 1'b1, 1'b1);
        finishFrame("tp_max_zero", 1'b1, 32'h4000_0000, 16'd3, 1'b0, 1'b0);

        $display("[TB] directed: NaN enabled and masked");
        startFrame();
        applyStimulus(pack4(32'h3F80_0000, 32'h7FC0_0001, 32'hFF80_0000, 32'h40A0_0000), 4'b1111, 1'b1, 1'b1);
        finishFrame("tp_nan", 1'b1, 32'hFFFF_FFFF, 16'd1, 1'b1, 1'b0);
        startFrame();
        applyStimulus(pack4(32'h3F80_0000, 32'h7FC0_0001, 32'hFF80_0000, 32'h40A0_0000), 4'b1101, 1'b1, 1'b1);
        finishFrame("tp_nan_masked", 1'b1, 32'h40A0_0000, 16'd3, 1'b0, 1'b0);

        $display("[TB] directed: empty frame and disabled first beat");
        startFrame();
        applyStimulus(pack4(32'h4040_0000, 32'h7FC0_0000, 32'h3F80_0000, 32'hC000_0000), 4'b0000, 1'b1, 1'b1);
        finishFrame("tp_empty", 1'b1, 32'h0, 16'd0, 1'b0, 1'b1);
        startFrame();
        applyStimulus(pack4(32'h7FC0_0000, 32'h4100_0000, 32'h4110_0000, 32'h4120_0000), 4'b0000, 1'b0, 1'b1);
        applyStimulus(pack4(32'h4100_0000, 32'h4110_0000, 32'h40E0_0000, 32'h4120_0000), 4'b0100, 1'b1, 1'b0);
        finishFrame("tp_disabled", 1'b1, 32'h40E0_0000, 16'd6, 1'b0, 1'b0);

        $display("[TB] directed: result backpressure");
        bus.i_res_ready = 1'b0;
        startFrame();
        applyStimulus(pack4(32'hC000_0000, 32'h3F00_0000, 32'h4020_0000, 32'h3F80_0000), 4'b1111, 1'b1, 1'b1);
        finishFrame("bp", 1'b1, 32'h4020_0000, 16'd2, 1'b0, 1'b0);
        heldRes = bus.o_res;
        bus.i_data    = pack4(32'h4700_0000, 32'h4700_0000, 32'h4700_0000, 32'h4700_0000);
        bus.i_lane_en = 4'b1111;
        bus.i_last    = 1'b1;
        bus.i_valid   = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checkOutput("bp_hold_valid", {31'b0, bus.o_res_valid}, 32'd1);
            checkOutput("bp_hold_res", bus.o_res, expRes);
            checkOutput("bp_hold_idx", {16'b0, bus.o_res_idx}, {16'b0, expIdx});
            checkOutput("bp_hold_ready", {31'b0, bus.i_ready}, 32'd0);
        end
        bus.i_valid     = 1'b0;
        bus.i_res_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_valid_drop", {31'b0, bus.o_res_valid}, 32'd0);
        checkOutput("bp_ready_rise", {31'b0, bus.i_ready}, 32'd1);
        checkOutput("bp_res_kept", heldRes, 32'h4020_0000);
        @(posedge clk);
        #1;

        $display("[TB] directed: reset mid-frame");
        startFrame();
        applyStimulus(pack4(32'h4100_0000, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000), 4'b1111, 1'b0, 1'b1);
        applyStimulus(pack4(32'h4200_0000, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000), 4'b1111, 1'b0, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        anyValid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            anyValid = anyValid | bus.o_res_valid;
        end
        checkOutput("rst_mid_no_result", {31'b0, anyValid}, 32'd0);
        checkOutput("rst_mid_ready", {31'b0, bus.i_ready}, 32'd1);
        @(posedge clk);
        #1;
        startFrame();
        applyStimulus(pack4(32'h4000_0000, 32'hBF80_0000, 32'h4100_0000, 32'h3F80_0000), 4'b1111, 1'b1, 1'b0);
        finishFrame("rst_mid_next", 1'b1, 32'hBF80_0000, 16'd1, 1'b0, 1'b0);

        $display("[TB] randomized frames");
        for (int f = 0; f < 40; f++) begin
            startFrame();
            nb = $urandom_range(1, 4);
            for (int b = 0; b < nb; b++) begin
                bubble = $urandom_range(0, 3);
                if (bubble > 1) begin
                    repeat (bubble - 1) @(posedge clk);
                    #1;
                end
                applyStimulus(pack4(randVal(), randVal(), randVal(), randVal()),
                              ($urandom_range(0, 7) == 0) ? 4'b0000 : 4'($urandom()),
                              (b == nb - 1), 1'($urandom()));
            end
            finishFrame("rand", 1'b0, 32'h0, 16'h0, 1'b0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
